// File: rtl/mult_pipe.sv
// Pipelined RV32M multiplier (MUL/MULH/MULHSU/MULHU) feeding one execute-result FIFO lane.
// Latency: NUM_STAGES cycles from the start edge to the registered done/ex_packet_out.
// Backpressure: none; one issue per cycle, and the downstream lane always absorbs a packet.

`ifndef XLEN
`define XLEN 32
`endif

package mult_pipe_pkg;
  localparam int XLEN = `XLEN;

  typedef struct packed {
    logic [XLEN-1:0] NPC;
    logic [XLEN-1:0] alu_result;
    logic            take_branch;
    logic [4:0]      dest_reg_idx;
    logic            halt;
    logic            illegal;
    logic            csr_op;
    logic            rd_mem;
    logic            wr_mem;
    logic [2:0]      mem_size;
    logic            is_ZEROREG;
    logic            valid;
  } EX_PACKET;

  localparam logic [1:0] FUNC_MUL    = 2'd0;
  localparam logic [1:0] FUNC_MULH   = 2'd1;
  localparam logic [1:0] FUNC_MULHSU = 2'd2;
  localparam logic [1:0] FUNC_MULHU  = 2'd3;
endpackage

module mult_pipe #(
  parameter int NUM_STAGES = 4,
  parameter int XLEN       = `XLEN
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [XLEN-1:0]           rs1_value,
  input  logic [XLEN-1:0]           rs2_value,
  input  logic [1:0]                func,
  input  mult_pipe_pkg::EX_PACKET   ex_in,
  input  logic                      flush,
  output mult_pipe_pkg::EX_PACKET   ex_packet_out,
  output logic                      done
);

  // Multiplier bits consumed per stage; NUM_STAGES must divide XLEN.
  localparam int CW = XLEN / NUM_STAGES;
  localparam int DW = 2 * XLEN;

  // Empty-lane encoding expected by the result FIFO.
  localparam mult_pipe_pkg::EX_PACKET IDLE_PKT = '{is_ZEROREG: 1'b1, default: '0};

  typedef struct packed {
    logic                    vld;
    logic [1:0]              func;
    logic [DW-1:0]           mcand;
    logic [DW-1:0]           mplier;
    logic [DW-1:0]           sum;
    mult_pipe_pkg::EX_PACKET pkt;
  } stage_t;

  stage_t                  issue;
  stage_t                  stg_q [NUM_STAGES];
  stage_t                  stg_d [NUM_STAGES];
  mult_pipe_pkg::EX_PACKET result_pkt;
  logic                    rs1_signed;
  logic                    rs2_signed;

  // Extend both operands to 2*XLEN so every op reduces to one modular product.
  always_comb begin
    rs1_signed   = (func != mult_pipe_pkg::FUNC_MULHU);
    rs2_signed   = ~func[1];
    issue        = '0;
    issue.vld    = start;
    issue.func   = func;
    issue.mcand  = {{XLEN{rs1_signed & rs1_value[XLEN-1]}}, rs1_value};
    issue.mplier = {{XLEN{rs2_signed & rs2_value[XLEN-1]}}, rs2_value};
    issue.pkt    = ex_in;
  end

  // Each stage adds one shifted partial product; the last stage takes every
  // remaining multiplier bit so the sign extension lands in the modular sum.
  always_comb begin
    stage_t        src;
    logic [DW-1:0] chunk;
    src   = '0;
    chunk = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      stg_d[k] = '0;
      src = (k == 0) ? issue : stg_q[(k > 0) ? k - 1 : 0];
      if (k == NUM_STAGES - 1) begin
        chunk = src.mplier;
      end else begin
        chunk = DW'(src.mplier[CW-1:0]);
      end
      stg_d[k]        = src;
      stg_d[k].vld    = src.vld & ~flush;
      stg_d[k].mplier = src.mplier >> CW;
      stg_d[k].sum    = src.sum + ((src.mcand * chunk) << (k * CW));
    end
  end

  // Pick the low or high product half and format the outgoing packet.
  always_comb begin
    result_pkt             = stg_q[NUM_STAGES-1].pkt;
    result_pkt.alu_result  = (stg_q[NUM_STAGES-1].func == mult_pipe_pkg::FUNC_MUL) ?
                             stg_q[NUM_STAGES-1].sum[XLEN-1:0] :
                             stg_q[NUM_STAGES-1].sum[DW-1:XLEN];
    result_pkt.valid       = 1'b1;
    result_pkt.take_branch = 1'b0;
  end

  // Stage and output registers; flush squashes the op leaving the last stage too,
  // but a packet already on the output is left alone for this cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        stg_q[k] <= '0;
      end
      done          <= 1'b0;
      ex_packet_out <= IDLE_PKT;
    end else begin
      stg_q <= stg_d;
      if (stg_q[NUM_STAGES-1].vld && !flush) begin
        done          <= 1'b1;
        ex_packet_out <= result_pkt;
      end else begin
        done          <= 1'b0;
        ex_packet_out <= IDLE_PKT;
      end
    end
  end

endmodule

// File: tb/tb_mult_pipe.sv
// Scoreboard bench for mult_pipe: directed vectors push expected packets, a
// negedge monitor pops and compares them whenever done is seen, and checks the
// idle encoding on every other cycle.
module tb_mult_pipe;
  import mult_pipe_pkg::*;

  localparam int NS = 4;
  localparam int XL = 32;

  logic        clock;
  logic        reset;
  logic        start;
  logic        flush;
  logic [31:0] rs1_value;
  logic [31:0] rs2_value;
  logic [1:0]  func;
  EX_PACKET    ex_in;
  EX_PACKET    ex_packet_out;
  logic        done;

  typedef struct {
    EX_PACKET pkt;
    int       cyc;
  } exp_t;

  exp_t     sb[$];
  int       total = 0;
  int       bad = 0;
  int       cyc = 0;
  bit       mon_en = 0;
  EX_PACKET idle_pkt;

  mult_pipe #(.NUM_STAGES(NS), .XLEN(XL)) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .rs1_value     (rs1_value),
    .rs2_value     (rs2_value),
    .func          (func),
    .ex_in         (ex_in),
    .flush         (flush),
    .ex_packet_out (ex_packet_out),
    .done          (done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc = cyc + 1;

  // Monitor: compare on done, otherwise require the idle lane encoding.
  always @(negedge clock) begin
    if (mon_en) begin
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done cyc=%0d got=%h want=no result", cyc, ex_packet_out);
        end else begin
          exp_t e;
          e = sb.pop_front();
          total++;
          if (ex_packet_out !== e.pkt) begin
            bad++;
            $display("FAIL packet cyc=%0d got=%h want=%h (alu got=%h want=%h)",
                     cyc, ex_packet_out, e.pkt, ex_packet_out.alu_result, e.pkt.alu_result);
          end
          total++;
          if (cyc != e.cyc) begin
            bad++;
            $display("FAIL latency got_cyc=%0d want_cyc=%0d", cyc, e.cyc);
          end
        end
      end else begin
        total++;
        if (ex_packet_out !== idle_pkt || done !== 1'b0) begin
          bad++;
          $display("FAIL idle cyc=%0d got done=%b pkt=%h want done=0 pkt=%h",
                   cyc, done, ex_packet_out, idle_pkt);
        end
        if (sb.size() > 0 && sb[0].cyc <= cyc) begin
          exp_t m;
          m = sb.pop_front();
          total++; bad++;
          $display("FAIL missing_done cyc=%0d got done=0 want alu=%h at cyc=%0d",
                   cyc, m.pkt.alu_result, m.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue one op; chk=1 records the expected packet, fl drives flush on the same edge.
  task automatic drive(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] res, input bit chk,
                       input bit fl);
    EX_PACKET ex;
    exp_t     e;
    ex              = '0;
    ex.NPC          = 32'h1000 + rd * 4;
    ex.alu_result   = 32'hDEAD_BEEF;
    ex.take_branch  = 1'b1;
    ex.dest_reg_idx = rd;
    ex.halt         = rd[0];
    ex.csr_op       = rd[1];
    ex.mem_size     = rd[2:0];
    ex.is_ZEROREG   = (rd == 5'd0);
    ex.valid        = 1'b0;
    func      = f;
    rs1_value = a;
    rs2_value = b;
    ex_in     = ex;
    start     = 1'b1;
    flush     = fl;
    if (chk) begin
      e.pkt             = ex;
      e.pkt.alu_result  = res;
      e.pkt.valid       = 1'b1;
      e.pkt.take_branch = 1'b0;
      e.cyc             = cyc + 1 + NS;
      sb.push_back(e);
    end
    tick();
    start = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    idle_pkt            = '0;
    idle_pkt.is_ZEROREG = 1'b1;
    reset     = 1'b1;
    start     = 1'b0;
    flush     = 1'b0;
    func      = 2'd0;
    rs1_value = '0;
    rs2_value = '0;
    ex_in     = '0;
    #2 reset = 1'b0;
    #1 mon_en = 1;
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b1;

    // Idle with start low.
    repeat (10) tick();

    // Single op latency and result.
    drive(FUNC_MUL, 32'd7, 32'd6, 5'd5, 32'd42, 1, 0);
    repeat (6) tick();

    // Sign handling and high-half selection, issued back-to-back.
    drive(FUNC_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'h0000_0000, 1, 0);
    drive(FUNC_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, 1, 0);
    drive(FUNC_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, 1, 0);
    drive(FUNC_MUL,    32'h8000_0000, 32'd2,         5'd9,  32'h0000_0000, 1, 0);
    drive(FUNC_MULH,   32'h8000_0000, 32'h8000_0000, 5'd10, 32'h4000_0000, 1, 0);
    drive(FUNC_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1, 0);
    drive(FUNC_MULH,   32'h7FFF_FFFF, 32'h8000_0000, 5'd12, 32'hC000_0000, 1, 0);
    drive(FUNC_MULH,   32'hFFFF_FFFD, 32'd5,         5'd13, 32'hFFFF_FFFF, 1, 0);
    drive(FUNC_MUL,    32'hFFFF_FFFD, 32'd5,         5'd0,  32'hFFFF_FFF1, 1, 0);
    repeat (6) tick();

    // Four consecutive issues.
    drive(FUNC_MUL, 32'd3,      32'd5,       5'd1, 32'd15,        1, 0);
    drive(FUNC_MUL, 32'd10,     32'd10,      5'd2, 32'd100,       1, 0);
    drive(FUNC_MUL, 32'd0,      32'd9,       5'd3, 32'd0,         1, 0);
    drive(FUNC_MUL, 32'h0000_FFFF, 32'h0001_0001, 5'd4, 32'hFFFF_FFFF, 1, 0);
    repeat (6) tick();

    // Flush squashes two in-flight ops and a start on the flush edge; next issue works.
    drive(FUNC_MUL, 32'd2, 32'd2, 5'd14, 32'd4,  0, 0);
    drive(FUNC_MUL, 32'd4, 32'd4, 5'd15, 32'd16, 0, 0);
    drive(FUNC_MUL, 32'd9, 32'd9, 5'd16, 32'd81, 0, 1);
    drive(FUNC_MUL, 32'd2, 32'd3, 5'd17, 32'd6,  1, 0);
    repeat (6) tick();

    // Flush while a result sits on the output: that packet is still delivered.
    drive(FUNC_MUL, 32'd11, 32'd11, 5'd18, 32'd121, 1, 0);
    repeat (4) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (4) tick();

    // Reset while ops are in flight and one is on the output.
    drive(FUNC_MUL, 32'd12, 32'd12, 5'd19, 32'd144, 1, 0);
    drive(FUNC_MUL, 32'd13, 32'd13, 5'd20, 32'd169, 0, 0);
    drive(FUNC_MUL, 32'd14, 32'd14, 5'd21, 32'd196, 0, 0);
    tick();
    tick();
    tick();
    reset = 1'b0;
    #1;
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL async_reset_done got=%b want=0", done);
    end
    total++;
    if (ex_packet_out !== idle_pkt) begin
      bad++;
      $display("FAIL async_reset_pkt got=%h want=%h", ex_packet_out, idle_pkt);
    end
    repeat (2) tick();
    reset = 1'b1;
    repeat (10) tick();
    drive(FUNC_MUL, 32'd5, 32'd5, 5'd22, 32'd25, 1, 0);
    repeat (8) tick();

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL leftover got=%0d pending want=0", sb.size());
    end
    mon_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_pipe.md
# mult_pipe

Pipelined multiplier for the RISC-V M-extension multiply ops: MUL, MULH, MULHSU and MULHU. It sits in the execute stage, directly upstream of the three-lane execute-result FIFO, and drives one of that FIFO's input lanes with a completed EX_PACKET. It accepts one operation per cycle and has fixed latency. A flush input squashes in-flight work on branch mispredict.

## Interface
- NUM_STAGES, 4, pipeline depth. Must divide XLEN; each stage consumes XLEN/NUM_STAGES multiplier bits.
- XLEN, `XLEN (32), operand width.
- clock  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset). Assertion clears state immediately; deassertion is synchronous to clock.
- start  input  1  issue strobe; the operation is sampled on the rising edge where start=1.
- rs1_value  input  XLEN  multiplicand.
- rs2_value  input  XLEN  multiplier.
- func  input  2  operation: 0=MUL, 1=MULH, 2=MULHSU, 3=MULHU.
- ex_in  input  EX_PACKET  carried fields (NPC, dest_reg_idx, halt, illegal, csr_op, mem fields, is_ZEROREG). Its alu_result is ignored.
- flush  input  1  squash all in-flight operations.
- ex_packet_out  output  EX_PACKET  result packet, routed to the FIFO lane.
- done  output  1  ex_packet_out holds a valid result this cycle.

## Operation
- Each stage register holds: valid, func, 2·XLEN-bit sign/zero-extended multiplicand, remaining multiplier bits, 2·XLEN-bit partial sum, and the carried EX_PACKET fields.
- Operand extension:
  - MUL and MULH: rs1 and rs2 sign-extended.
  - MULHSU: rs1 sign-extended, rs2 zero-extended.
  - MULHU: both zero-extended.
- Stage k adds (multiplicand · multiplier chunk k) << (k·XLEN/NUM_STAGES) to the partial sum.
  - Arithmetic is modulo 2^(2·XLEN). Overflow bits are discarded.
  - The top chunk of a sign-extended multiplier is handled by extending the multiplier to 2·XLEN bits and summing modulo 2^(2·XLEN). The result must equal the low 2·XLEN bits of the exact signed/unsigned product.
- Result selection:
  - MUL: alu_result = product[XLEN-1:0].
  - MULH, MULHSU, MULHU: alu_result = product[2·XLEN-1:XLEN].
- Valid output packet: ex_in fields carried unchanged, alu_result set, valid=1, take_branch=0.
- Idle output encoding (the FIFO's empty lane):
  - ex_packet_out is all-zero except is_ZEROREG=1.
  - done=0.
- No backpressure: the downstream FIFO absorbs one packet per cycle per lane.
- Flush at a rising edge:
  - All stage valid bits clear.
  - A start sampled on the same edge is dropped.
  - The next cycle's output is idle.
- A zero product is a legitimate result: done=1, alu_result=0, valid=1.

## Timing
- Latency: start sampled at edge N gives done=1 with the result between edge N+NUM_STAGES and edge N+NUM_STAGES+1. All outputs are registered.
- Throughput: one issue per cycle. Back-to-back issues produce back-to-back results in issue order.
- Reset values:
  - All stage valids 0.
  - done=0.
  - ex_packet_out in idle encoding (all zero, is_ZEROREG=1).
- Reset asserted mid-operation: all in-flight operations are lost with no output. The first valid output after release comes NUM_STAGES edges after the first post-reset start.
- flush and done in the same cycle: the packet currently on the output is delivered. Only operations still in stages are squashed.
- Issue in the cycle after a flush is accepted normally.

## Test plan
- MUL 7 × 6, start for one cycle -> done=1 exactly 4 edges later with alu_result=42 and dest_reg_idx equal to the issued value; done=0 in every other cycle.
- MULH 0xFFFFFFFF × 0xFFFFFFFF -> 0x00000000. MULHU same operands -> 0xFFFFFFFE. MULHSU same operands -> 0xFFFFFFFF. MUL 0x80000000 × 2 -> 0x00000000 with done=1.
- Four consecutive starts (3×5, 10×10, 0×9, 0xFFFF×0x10001) -> four consecutive done cycles, in order, with 15, 100, 0, 0xFFFFFFFF.
- Issue two ops, assert flush on the edge after the second -> neither result appears, output stays idle. A MUL 2×3 issued the next cycle returns 6 four edges later.
- Drop reset to 0 while three ops are in flight -> done=0 and idle packet immediately (asynchronous). Nothing emerges after release until a new start.
- Idle with start=0 for 10 cycles -> done=0, alu_result=0, is_ZEROREG=1 throughout.
